// File: rtl/key_conditioner.sv
// key_conditioner: push-button front end.
// Synchronizes, debounces and edge-detects KEY_WIDTH raw mechanical keys.
// It produces clean levels, one-cycle press/release pulses and the index of
// the lowest-numbered pressed key.
// Optional long-press detection is enabled by defining the macro
// KEY_CONDITIONER_LONG_PRESS_EN. With the macro undefined, key_long is tied to 0.
module key_conditioner #(
    parameter int KEY_WIDTH       = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_WIDTH       = 20,
    parameter int ACTIVE_LOW      = 1,
    parameter int CODE_WIDTH      = 2
`ifdef KEY_CONDITIONER_LONG_PRESS_EN
    ,
    parameter int LONG_CYCLES     = 50000000
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [KEY_WIDTH-1:0]  key_raw,
    output logic [KEY_WIDTH-1:0]  key_level,
    output logic [KEY_WIDTH-1:0]  key_press,
    output logic [KEY_WIDTH-1:0]  key_release,
    output logic                  key_any,
    output logic [CODE_WIDTH-1:0] key_code,
    output logic [KEY_WIDTH-1:0]  key_long
);

    // Inverting mask so that a normalized bit of 1 always means "pressed"
    localparam logic [KEY_WIDTH-1:0] INV_MASK =
        (ACTIVE_LOW != 0) ? {KEY_WIDTH{1'b1}} : {KEY_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [KEY_WIDTH-1:0] key_norm;
    logic [KEY_WIDTH-1:0] sync_meta;
    logic [KEY_WIDTH-1:0] sync_out;
    logic [CNT_WIDTH-1:0] cnt [KEY_WIDTH];

    assign key_norm = key_raw ^ INV_MASK;

    // Two-flop synchronizer per key; reset loads the released value
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= '0;
            sync_out  <= '0;
        end else begin
            sync_meta <= key_norm;
            sync_out  <= sync_meta;
        end
    end

    // Per-key debounce: count consecutive samples that disagree with the level and accept on the last one
    always_ff @(posedge clk) begin
        if (rst) begin
            key_level   <= '0;
            key_press   <= '0;
            key_release <= '0;
            for (int i = 0; i < KEY_WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < KEY_WIDTH; i++) begin
                key_press[i]   <= 1'b0;
                key_release[i] <= 1'b0;
                if (sync_out[i] == key_level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    key_level[i]   <= sync_out[i];
                    key_press[i]   <= sync_out[i];
                    key_release[i] <= ~sync_out[i];
                    cnt[i]         <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign key_any = |key_level;

    // Priority encoder: scan downward so the lowest pressed index is the last to write
    always_comb begin
        key_code = '0;
        for (int i = KEY_WIDTH - 1; i >= 0; i--) begin
            if (key_level[i]) begin
                key_code = CODE_WIDTH'(i);
            end
        end
    end

`ifdef KEY_CONDITIONER_LONG_PRESS_EN
    localparam int LONG_W = $clog2(LONG_CYCLES + 1);
    localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CYCLES);
    localparam logic [LONG_W-1:0] LONG_PRE  = LONG_W'(LONG_CYCLES - 1);

    logic [LONG_W-1:0] long_cnt [KEY_WIDTH];

    // Hold-time counter per key: saturates at LONG_CYCLES and pulses once on arrival
    always_ff @(posedge clk) begin
        if (rst) begin
            key_long <= '0;
            for (int i = 0; i < KEY_WIDTH; i++) begin
                long_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < KEY_WIDTH; i++) begin
                key_long[i] <= 1'b0;
                if (!key_level[i]) begin
                    long_cnt[i] <= '0;
                end else if (long_cnt[i] != LONG_MAX) begin
                    long_cnt[i] <= long_cnt[i] + LONG_W'(1);
                    key_long[i] <= (long_cnt[i] == LONG_PRE);
                end
            end
        end
    end
`else
    assign key_long = '0;
`endif

endmodule
